// File: rtl/afc_pkg.sv
// AFC comparator shared constants: one-hot verdict codes
// (also used by the band FSM) and comparator state encoding.
package afc_pkg;

  localparam logic [2:0] COMP_NONE   = 3'b000;
  localparam logic [2:0] COMP_FAST   = 3'b100;
  localparam logic [2:0] COMP_SLOW   = 3'b010;
  localparam logic [2:0] COMP_FREEZE = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_CMP,
    ST_DONE
  } cmp_state_e;

endpackage

// File: rtl/afc_sync_edge.sv
// 2-flop synchronizer plus delay flop; rise pulses for one
// clk on each synchronized rising edge of async_in.
module afc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic sd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      sd <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      sd <= s2;
    end
  end

  assign rise = s2 & ~sd;

endmodule

// File: rtl/afc_freq_comparator.sv
// AFC frequency comparator: counts vco_div edges over a clk window
// after a settle time, issues a one-hot verdict to the band FSM.
// Ports: clk, rst_n, en, vco_div, fsm_state[4]=finish in;
// comp_out, meas_done, count_out, busy out.
module afc_freq_comparator
  import afc_pkg::*;
#(
  parameter int CNT_W         = 12,
  parameter int WINDOW_CYCLES = 256,
  parameter int SETTLE_CYCLES = 16,
  parameter int TARGET        = 64,
  parameter int TOL           = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vco_div,
  input  logic [4:0]       fsm_state,
  output logic [2:0]       comp_out,
  output logic             meas_done,
  output logic [CNT_W-1:0] count_out,
  output logic             busy
);

  localparam int TMR_MAX =
    (WINDOW_CYCLES > SETTLE_CYCLES) ?
    WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W:0] HI =
    (CNT_W+1)'(TARGET + TOL);
  localparam logic [CNT_W:0] LO =
    (TOL >= TARGET) ? '0 : (CNT_W+1)'(TARGET - TOL);

  cmp_state_e       state_q;
  cmp_state_e       state_d;
  logic [TMR_W-1:0] tmr_q;
  logic             tmr_zero;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W:0]   cnt_x;
  logic [2:0]       verdict;
  logic             rise;
  logic             fin;
  logic             unused_band;

  assign fin         = fsm_state[4];
  assign unused_band = ^fsm_state[3:0];
  assign tmr_zero    = (tmr_q == '0);
  assign cnt_x       = {1'b0, edge_cnt};

  afc_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (vco_div),
    .rise     (rise)
  );

  always_comb begin
    verdict = COMP_FREEZE;
    if (cnt_x > HI)
      verdict = COMP_FAST;
    else if (cnt_x < LO)
      verdict = COMP_SLOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (en)
          state_d = fin ? ST_DONE : ST_SETTLE;
      ST_SETTLE:
        if (fin)           state_d = ST_DONE;
        else if (tmr_zero) state_d = ST_COUNT;
      ST_COUNT:
        if (fin)           state_d = ST_DONE;
        else if (tmr_zero) state_d = ST_CMP;
      ST_CMP:
        state_d = (verdict == COMP_FREEZE) ?
                  ST_DONE : ST_SETTLE;
      ST_DONE:
        state_d = ST_DONE;
      default:
        state_d = ST_IDLE;
    endcase
    if (!en) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q     <= '0;
      edge_cnt  <= '0;
      comp_out  <= COMP_NONE;
      meas_done <= 1'b0;
      count_out <= '0;
    end else begin
      comp_out  <= COMP_NONE;
      meas_done <= 1'b0;
      if (state_d == ST_SETTLE &&
          state_q != ST_SETTLE) begin
        tmr_q <= TMR_W'(SETTLE_CYCLES - 1);
      end else if (state_d == ST_COUNT &&
                   state_q != ST_COUNT) begin
        tmr_q    <= TMR_W'(WINDOW_CYCLES - 1);
        edge_cnt <= '0;
      end else if (!tmr_zero) begin
        tmr_q <= tmr_q - 1'b1;
      end
      if (state_q == ST_COUNT && rise &&
          edge_cnt != '1)
        edge_cnt <= edge_cnt + 1'b1;
      // en low in CMP drops the verdict and keeps the old count
      if (state_q == ST_CMP && en) begin
        comp_out  <= verdict;
        meas_done <= 1'b1;
        count_out <= edge_cnt;
      end
    end
  end

  assign busy = (state_q == ST_SETTLE) ||
                (state_q == ST_COUNT)  ||
                (state_q == ST_CMP);

endmodule

// File: tb/tb_afc_freq_comparator.sv
// Bench for afc_freq_comparator: cycle model plus directed
// scenarios with literal expectations.
module tb_afc_freq_comparator;

  localparam int S    = 16;
  localparam int W    = 256;
  localparam int CMAX = 4095;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        en2 = 1'b0;
  logic        vco_div = 1'b0;
  logic [4:0]  fsm_state = 5'b0;
  logic [4:0]  fsm_zero = 5'b0;
  logic [2:0]  comp_out;
  logic        meas_done;
  logic [11:0] count_out;
  logic        busy;
  logic [2:0]  comp2;
  logic        md2;
  logic [5:0]  cnt2;
  logic        busy2;

  int checks = 0;
  int errors = 0;
  int per = 4;
  int vph = 0;

  afc_freq_comparator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .vco_div   (vco_div),
    .fsm_state (fsm_state),
    .comp_out  (comp_out),
    .meas_done (meas_done),
    .count_out (count_out),
    .busy      (busy)
  );

  afc_freq_comparator #(.CNT_W(6)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en2),
    .vco_div   (vco_div),
    .fsm_state (fsm_zero),
    .comp_out  (comp2),
    .meas_done (md2),
    .count_out (cnt2),
    .busy      (busy2)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    if (per == 0) begin
      vph = 0;
      vco_div = 1'b0;
    end else begin
      vph = (vph + 1) % per;
      vco_div = (vph < per / 2);
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 measuring, 2 done. ph counts clk
  // edges since measurement start: settle 1..S, window S+1..S+W,
  // verdict registered at S+W+1. Edge seen by the counter is the
  // vco sample from two edges back rising over three edges back.
  int          m_mode = 0;
  int          m_ph = 0;
  int          m_cnt = 0;
  int          m_count = 0;
  logic [2:0]  m_comp = 3'b0;
  logic        m_md = 1'b0;
  logic        h0 = 1'b0;
  logic        h1 = 1'b0;
  logic        h2 = 1'b0;
  logic        m_e;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_ph = 0; m_cnt = 0;
      m_count = 0; m_comp = 3'b0; m_md = 1'b0;
      h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    end else begin
      m_e = h1 & ~h2;
      h2 = h1; h1 = h0; h0 = vco_div;
      m_comp = 3'b0;
      m_md = 1'b0;
      if (!en) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (fsm_state[4]) m_mode = 2;
        else begin
          m_mode = 1; m_ph = 0; m_cnt = 0;
        end
      end else if (m_mode == 1) begin
        m_ph++;
        if (m_ph <= S + W && fsm_state[4]) begin
          m_mode = 2;
        end else if (m_ph > S && m_ph <= S + W) begin
          if (m_e && m_cnt < CMAX) m_cnt++;
        end else if (m_ph == S + W + 1) begin
          m_count = m_cnt;
          m_md = 1'b1;
          if (m_cnt > 65)      m_comp = 3'b100;
          else if (m_cnt < 63) m_comp = 3'b010;
          else                 m_comp = 3'b001;
          if (m_comp == 3'b001) m_mode = 2;
          else begin
            m_ph = 0; m_cnt = 0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("m_comp", 32'(comp_out), 32'(m_comp));
    chk("m_done", 32'(meas_done), 32'(m_md));
    chk("m_busy", 32'(busy), 32'(m_mode == 1));
    chk("m_count", 32'(count_out), 32'(m_count));
  end

  task automatic wait_pulse(input int maxc,
                            output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!meas_done && n < maxc);
    chk("pulse_seen", 32'(meas_done), 32'd1);
  endtask

  int n;
  int pulses;
  int k;
  logic [3:0] band;
  logic [3:0] msk;

  initial begin
    per = 4;
    repeat (3) @(negedge clk);
    chk("rst_comp", 32'(comp_out), 32'd0);
    chk("rst_done", 32'(meas_done), 32'd0);
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: in band
    en = 1'b1;
    wait_pulse(400, n);
    chk("t1_latency", 32'(n), 32'd274);
    chk("t1_freeze", 32'(comp_out), 32'd1);
    chk("t1_count", 32'(count_out), 32'd64);
    @(negedge clk);
    chk("t1_comp_clr", 32'(comp_out), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // 2: fast, plus saturating 6-bit instance
    per = 3;
    repeat (4) @(negedge clk);
    en = 1'b1;
    en2 = 1'b1;
    wait_pulse(400, n);
    chk("t2_fast", 32'(comp_out), 32'd4);
    chk("t2_cnt_85_86",
        32'(count_out == 85 || count_out == 86), 32'd1);
    chk("t7_sat_count", 32'(cnt2), 32'd63);
    chk("t7_sat_freeze", 32'(comp2), 32'd1);
    chk("t7_sat_done", 32'(md2), 32'd1);
    wait_pulse(400, n);
    chk("t2_spacing", 32'(n), 32'd273);
    chk("t2_fast2", 32'(comp_out), 32'd4);
    @(negedge clk);
    chk("t2_busy", 32'(busy), 32'd1);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // 3: slow
    per = 8;
    en = 1'b1;
    wait_pulse(400, n);
    chk("t3_slow", 32'(comp_out), 32'd2);
    chk("t3_count", 32'(count_out), 32'd32);
    wait_pulse(400, n);
    chk("t3_spacing", 32'(n), 32'd273);
    chk("t3_slow2", 32'(comp_out), 32'd2);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // 4: closed loop with a binary-search band FSM
    band = 4'b1000;
    msk = 4'b1000;
    fsm_state = {1'b0, band};
    per = 3;
    repeat (4) @(negedge clk);
    en = 1'b1;
    pulses = 0;
    k = 0;
    while (!fsm_state[4] && k < 1500) begin
      @(negedge clk);
      k++;
      if (comp_out != 3'b0) begin
        pulses++;
        if (comp_out == 3'b100)
          band = (band & ~msk) | (msk >> 1);
        else if (comp_out == 3'b010)
          band = band | (msk >> 1);
        msk = msk >> 1;
        fsm_state = {comp_out == 3'b001, band};
        per = (band > 4'b0100) ? 3 : 4;
      end
    end
    chk("t4_final", 32'(fsm_state), 32'b10100);
    chk("t4_pulses", 32'(pulses), 32'd2);
    repeat (2) @(negedge clk);
    chk("t4_busy", 32'(busy), 32'd0);
    en = 1'b0;
    fsm_state = 5'b0;
    per = 4;
    repeat (3) @(negedge clk);

    // 5: en dropped mid-window
    en = 1'b1;
    repeat (S + 101) @(negedge clk);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_comp", 32'(comp_out), 32'd0);
    chk("t5_count", 32'(count_out), 32'd64);
    pulses = 0;
    repeat (300) begin
      @(negedge clk);
      if (meas_done) pulses++;
    end
    chk("t5_no_pulse", 32'(pulses), 32'd0);
    en = 1'b1;
    wait_pulse(400, n);
    chk("t5_restart", 32'(n), 32'd274);
    chk("t5_freeze", 32'(comp_out), 32'd1);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // 6: finish during COUNT, then reset mid-window
    en = 1'b1;
    repeat (60) @(negedge clk);
    fsm_state = 5'b10000;
    @(negedge clk);
    chk("t6_done", 32'(busy), 32'd0);
    fsm_state = 5'b0;
    pulses = 0;
    repeat (300) begin
      @(negedge clk);
      if (meas_done) pulses++;
    end
    chk("t6_no_pulse", 32'(pulses), 32'd0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_comp", 32'(comp_out), 32'd0);
    chk("t6_rst_done", 32'(meas_done), 32'd0);
    chk("t6_rst_count", 32'(count_out), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
